// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator.
// Holds the FSM state enum, keycode/octave widths, the invalid-key constant
// and a helper that sizes voice index fields.
package voice_alloc_pkg;

    localparam int KEYCODE_W = 8;
    localparam int OCTAVE_W  = 3;

    localparam logic [KEYCODE_W-1:0] KEY_INVALID = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Width of an index able to address n voices (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oldest_voice_finder.sv
// Combinational search for the oldest voice: the highest age wins and a tie
// resolves to the lowest voice index.
module oldest_voice_finder
    import voice_alloc_pkg::*;
#(
    parameter int NUMVOICES = 4,
    parameter int AGE_W     = 4,
    parameter int IDX_W     = idx_width(NUMVOICES)
) (
    input  logic [AGE_W-1:0] ages [0:NUMVOICES-1],
    output logic [IDX_W-1:0] oldest_idx
);

    logic [AGE_W-1:0] best_age;

    // Linear scan; strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_age   = ages[0];
        oldest_idx = '0;
        for (int i = 1; i < NUMVOICES; i++) begin
            if (ages[i] > best_age) begin
                best_age   = ages[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key press/release events onto voice slots
// and requests phase-increment refreshes through per-voice rden pulses.
// Each event takes three cycles (IDLE -> LOOKUP -> UPDATE -> IDLE).
// Build option: define VOICE_STEAL_EN to steal the oldest voice when a press
// arrives with every voice gated; otherwise such a press is dropped.
//
// Handshake: an event is accepted on a rising edge where key_valid && key_ready;
// key_ready is high only in IDLE, so the producer holds key_valid (with stable
// key_code/key_release) until it sees key_ready, and one event is consumed per
// accept.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int NUMVOICES = 4,
    parameter int AGE_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [KEYCODE_W-1:0] key_code,
    input  logic                 key_release,
    output logic                 key_ready,
    input  logic [OCTAVE_W-1:0]  octave,
    output logic [KEYCODE_W-1:0] keycodes [0:NUMVOICES-1],
    output logic [NUMVOICES-1:0] rden,
    output logic [NUMVOICES-1:0] gate,
    output logic [OCTAVE_W-1:0]  octave_out,
    output logic                 overflow
);

    localparam int IDX_W = idx_width(NUMVOICES);

    state_t               state;
    logic [KEYCODE_W-1:0] ev_code;
    logic                 ev_release;
    logic [AGE_W-1:0]     ages [0:NUMVOICES-1];

    // Search results captured in LOOKUP and consumed in UPDATE.
    logic [IDX_W-1:0]     match_idx, free_idx, oldest_idx;
    logic                 match_hit, free_hit;

    // Live search results over the current voice table.
    logic [IDX_W-1:0]     match_c, free_c, oldest_c;
    logic                 match_found_c, free_found_c;

    // UPDATE-stage decision.
    logic                 touch, write_new, release_hit, overflow_c;
    logic [IDX_W-1:0]     touch_idx;

    oldest_voice_finder #(
        .NUMVOICES (NUMVOICES),
        .AGE_W     (AGE_W),
        .IDX_W     (IDX_W)
    ) u_oldest (
        .ages       (ages),
        .oldest_idx (oldest_c)
    );

    // Lowest gated voice holding the event code, and lowest free voice.
    always_comb begin
        match_c       = '0;
        match_found_c = 1'b0;
        free_c        = '0;
        free_found_c  = 1'b0;
        for (int i = NUMVOICES - 1; i >= 0; i--) begin
            if (gate[i] && (keycodes[i] == ev_code)) begin
                match_c       = IDX_W'(i);
                match_found_c = 1'b1;
            end
            if (!gate[i]) begin
                free_c       = IDX_W'(i);
                free_found_c = 1'b1;
            end
        end
    end

    // Decide what UPDATE does with the registered event and search results.
    always_comb begin
        touch       = 1'b0;
        write_new   = 1'b0;
        release_hit = 1'b0;
        overflow_c  = 1'b0;
        touch_idx   = match_idx;
        if (ev_code != KEY_INVALID) begin
            if (!ev_release) begin
                if (match_hit) begin
                    touch     = 1'b1;
                    touch_idx = match_idx;
                end else if (free_hit) begin
                    touch     = 1'b1;
                    write_new = 1'b1;
                    touch_idx = free_idx;
                end else begin
                    overflow_c = 1'b1;
                    touch_idx  = oldest_idx;
`ifdef VOICE_STEAL_EN
                    touch      = 1'b1;
                    write_new  = 1'b1;
`endif
                end
            end else if (match_hit) begin
                release_hit = 1'b1;
            end
        end
    end

    // Event FSM with registered voice table, pulses and octave latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            key_ready  <= 1'b1;
            ev_code    <= KEY_INVALID;
            ev_release <= 1'b0;
            match_idx  <= '0;
            free_idx   <= '0;
            oldest_idx <= '0;
            match_hit  <= 1'b0;
            free_hit   <= 1'b0;
            rden       <= '0;
            gate       <= '0;
            overflow   <= 1'b0;
            octave_out <= '0;
            for (int i = 0; i < NUMVOICES; i++) begin
                keycodes[i] <= KEY_INVALID;
                ages[i]     <= '0;
            end
        end else begin
            rden     <= '0;
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid && key_ready) begin
                        ev_code    <= key_code;
                        ev_release <= key_release;
                        key_ready  <= 1'b0;
                        state      <= LOOKUP;
                    end else if (octave != octave_out) begin
                        octave_out <= octave;
                        for (int i = 0; i < NUMVOICES; i++) begin
                            rden[i] <= (keycodes[i] != KEY_INVALID);
                        end
                    end
                end
                LOOKUP: begin
                    match_idx  <= match_c;
                    match_hit  <= match_found_c;
                    free_idx   <= free_c;
                    free_hit   <= free_found_c;
                    oldest_idx <= oldest_c;
                    state      <= UPDATE;
                end
                UPDATE: begin
                    overflow  <= overflow_c;
                    key_ready <= 1'b1;
                    state     <= IDLE;
                    if (touch) begin
                        for (int i = 0; i < NUMVOICES; i++) begin
                            if (IDX_W'(i) == touch_idx) begin
                                ages[i] <= '0;
                                gate[i] <= 1'b1;
                                rden[i] <= 1'b1;
                                if (write_new) begin
                                    keycodes[i] <= ev_code;
                                end
                            end else if (gate[i] && (ages[i] != '1)) begin
                                ages[i] <= ages[i] + 1'b1;
                            end
                        end
                    end
                    if (release_hit) begin
                        gate[match_idx] <= 1'b0;
                    end
                end
                default: begin
                    key_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed scenarios followed by randomized
// key/octave traffic, checked against a voice-table model kept in the bench.
module tb_voice_allocator;

    localparam int NV      = 4;
    localparam int AW      = 4;
    localparam int AGE_MAX = (1 << AW) - 1;

    logic          clk;
    logic          reset;
    logic          key_valid;
    logic [7:0]    key_code;
    logic          key_release;
    logic          key_ready;
    logic [2:0]    octave;
    logic [7:0]    keycodes [0:NV-1];
    logic [NV-1:0] rden;
    logic [NV-1:0] gate;
    logic [2:0]    octave_out;
    logic          overflow;

    voice_allocator #(
        .NUMVOICES (NV),
        .AGE_W     (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ready   (key_ready),
        .octave      (octave),
        .keycodes    (keycodes),
        .rden        (rden),
        .gate        (gate),
        .octave_out  (octave_out),
        .overflow    (overflow)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model of the voice table.
    logic [7:0]    m_code [NV];
    logic [NV-1:0] m_gate;
    int            m_age  [NV];
    logic [2:0]    m_oct;
    logic          exp_ovf;
    logic [NV-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_code[i] = 8'h00;
            m_age[i]  = 0;
        end
        m_gate  = '0;
        m_oct   = 3'd0;
        exp_ovf = 1'b0;
    endtask

    // Apply one key event to the model; queue the expected rden pulse.
    task automatic model_event(input logic [7:0] code, input logic rel);
        int match;
        int target;
        int best;
        logic [NV-1:0] pulse;
        pulse   = '0;
        exp_ovf = 1'b0;
        match   = -1;
        target  = -1;
        if (code != 8'h00) begin
            for (int i = NV - 1; i >= 0; i--)
                if (m_gate[i] && m_code[i] == code) match = i;
            if (rel) begin
                if (match >= 0) m_gate[match] = 1'b0;
            end else begin
                if (match >= 0) begin
                    target = match;
                end else begin
                    for (int i = NV - 1; i >= 0; i--)
                        if (!m_gate[i]) target = i;
                    if (target < 0) begin
                        exp_ovf = 1'b1;
`ifdef VOICE_STEAL_EN
                        best = 0;
                        for (int i = 1; i < NV; i++)
                            if (m_age[i] > m_age[best]) best = i;
                        target = best;
`endif
                    end
                end
                if (target >= 0) begin
                    for (int i = 0; i < NV; i++)
                        if (i != target && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
                    m_age[target]  = 0;
                    m_code[target] = code;
                    m_gate[target] = 1'b1;
                    pulse[target]  = 1'b1;
                end
            end
        end
        exp_q.push_back(pulse);
    endtask

    // Full output comparison against the model (pops one expected rden).
    task automatic check_all(input string tag);
        logic [NV-1:0] exp_rden;
        exp_rden = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, ".rden"}, rden, exp_rden);
        check({tag, ".gate"}, gate, m_gate);
        check({tag, ".overflow"}, overflow, exp_ovf);
        check({tag, ".octave_out"}, octave_out, m_oct);
        check({tag, ".key_ready"}, key_ready, 1'b1);
        for (int i = 0; i < NV; i++)
            check($sformatf("%s.keycodes[%0d]", tag, i), keycodes[i], m_code[i]);
        exp_ovf = 1'b0;
    endtask

    // One IDLE cycle with no event: octave change is applied if pending.
    task automatic idle_step(input string tag);
        logic [NV-1:0] pulse;
        pulse = '0;
        @(negedge clk);
        if (octave != m_oct) begin
            m_oct = octave;
            for (int i = 0; i < NV; i++) pulse[i] = (m_code[i] != 8'h00);
        end
        exp_q.push_back(pulse);
        check_all(tag);
    endtask

    task automatic do_reset(input logic with_valid);
        reset     = 1'b1;
        key_valid = with_valid;
        key_code  = 8'h1C;
        octave    = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        key_valid = 1'b0;
        model_reset();
        exp_q.push_back('0);
        check_all("reset");
    endtask

    // Present one event in IDLE; check busy cycles and the result 3 cycles on.
    task automatic send(input logic [7:0] code, input logic rel, input logic [2:0] oct, input string tag);
        int n;
        n = 0;
        while (!key_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".ready_wait"}, key_ready, 1'b1);
        key_valid   = 1'b1;
        key_code    = code;
        key_release = rel;
        octave      = oct;
        @(negedge clk);
        key_valid = 1'b0;
        check({tag, ".lookup_ready"}, key_ready, 1'b0);
        check({tag, ".lookup_rden"}, rden, '0);
        @(negedge clk);
        check({tag, ".update_ready"}, key_ready, 1'b0);
        check({tag, ".update_rden"}, rden, '0);
        model_event(code, rel);
        @(negedge clk);
        check_all(tag);
    endtask

    logic [7:0] code_tab [8];

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 8'h00;
        key_release = 1'b0;
        octave      = 3'd0;
        code_tab[0] = 8'h00; code_tab[1] = 8'h1C; code_tab[2] = 8'h1B; code_tab[3] = 8'h23;
        code_tab[4] = 8'h2B; code_tab[5] = 8'h24; code_tab[6] = 8'h55; code_tab[7] = 8'h4B;
        model_reset();

        // Reset with a simultaneous key_valid: reset wins.
        do_reset(1'b1);
        idle_step("reset_idle");

        // Reset abandons an event caught in LOOKUP.
        key_valid   = 1'b1;
        key_code    = 8'h1C;
        key_release = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('0);
        check_all("mid_reset");
        idle_step("mid_reset_idle");

        // Single press lands in voice 0.
        send(8'h1C, 1'b0, 3'd0, "press_1c");
        check("press_1c.code0_const", keycodes[0], 8'h1C);
        check("press_1c.gate_const", gate, 4'b0001);
        check("press_1c.rden_const", rden, 4'b0001);
        idle_step("press_1c_after");

        // Invalid keycode is absorbed.
        send(8'h00, 1'b0, 3'd0, "press_00");
        idle_step("press_00_after");

        // Octave change with voices 0 and 1 loaded.
        send(8'h1B, 1'b0, 3'd0, "press_1b");
        idle_step("press_1b_after");
        octave = 3'd2;
        idle_step("octave_2");
        check("octave_2.rden_const", rden, 4'b0011);
        idle_step("octave_2_after");

        // Octave change coincident with an accepted event.
        send(8'h23, 1'b0, 3'd5, "coincident");
        check("coincident.oct_held", octave_out, 3'd2);
        idle_step("coincident_oct");
        check("coincident.oct_applied", octave_out, 3'd5);
        idle_step("coincident_after");

        // Fill all voices then overflow.
        do_reset(1'b0);
        send(8'h1C, 1'b0, 3'd0, "fill_0");
        send(8'h1B, 1'b0, 3'd0, "fill_1");
        send(8'h23, 1'b0, 3'd0, "fill_2");
        send(8'h2B, 1'b0, 3'd0, "fill_3");
        send(8'h24, 1'b0, 3'd0, "overflow");
        check("overflow.pulse_const", overflow, 1'b1);
`ifdef VOICE_STEAL_EN
        check("overflow.steal_code0", keycodes[0], 8'h24);
        check("overflow.steal_rden", rden, 4'b0001);
`else
        check("overflow.drop_code0", keycodes[0], 8'h1C);
        check("overflow.drop_rden", rden, 4'b0000);
`endif
        idle_step("overflow_after");

        // Retrigger a held key.
        send(8'h23, 1'b0, 3'd0, "retrigger");
        idle_step("retrigger_after");

        // Release held key, then an unknown key.
        send(8'h1B, 1'b1, 3'd0, "release_1b");
        check("release_1b.gate1", gate[1], 1'b0);
        check("release_1b.code1", keycodes[1], 8'h1B);
        idle_step("release_1b_after");
        send(8'h55, 1'b1, 3'd0, "release_55");
        idle_step("release_55_after");

        // Randomized traffic.
        for (int it = 0; it < 120; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 8) begin
                send(code_tab[$urandom_range(0, 7)], ($urandom_range(0, 2) == 0), octave, "rnd_event");
                idle_step("rnd_event_after");
            end else if (r == 8) begin
                octave = 3'($urandom_range(0, 7));
                idle_step("rnd_octave");
                idle_step("rnd_octave_after");
            end else begin
                send(code_tab[$urandom_range(1, 7)], 1'b0, 3'($urandom_range(0, 7)), "rnd_coincident");
                idle_step("rnd_coincident_oct");
                idle_step("rnd_coincident_after");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUMVOICES, default 4: number of voice slots; equals NUMREADS of the phase-increment lookup it drives.
REQ-002 Parameter AGE_W, default 4: width of the per-voice saturating age counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_valid  input  1  key event present.
REQ-006 key_code  input  8  keyboard keycode; 0x00 is invalid.
REQ-007 key_release  input  1  1 = release (break) event, 0 = press (make) event.
REQ-008 key_ready  output  1  allocator can accept an event; an event is accepted when key_valid && key_ready.
REQ-009 octave  input  3  current octave select.
REQ-010 keycodes  output  8 x NUMVOICES  keycode held by each voice, indexed [0:NUMVOICES-1].
REQ-011 rden  output  NUMVOICES  one-cycle pulse per voice requesting a phase-increment refresh, indexed [0:NUMVOICES-1].
REQ-012 gate  output  NUMVOICES  voice key-down flag.
REQ-013 octave_out  output  3  octave latched for the lookup.
REQ-014 overflow  output  1  one-cycle pulse when a press arrives with all voices gated.

Function
REQ-015 The FSM SHALL have states IDLE, LOOKUP and UPDATE; key_ready SHALL be 1 only in IDLE.
REQ-016 An accepted event SHALL be registered, with IDLE->LOOKUP on the same edge, LOOKUP->UPDATE and UPDATE->IDLE unconditionally; outputs SHALL change on the UPDATE->IDLE edge, so the event-to-output latency is 3 cycles.
REQ-017 An event with key_code 0x00 SHALL be accepted and discarded with no output change.
REQ-018 LOOKUP SHALL register: the match index (lowest gated voice whose keycode equals the event code), the free index (lowest non-gated voice), and the oldest index (highest age; ties go to the lowest index).
REQ-019 Press with a match SHALL retrigger: that voice's age is cleared to 0, its keycode is unchanged and its rden pulses.
REQ-020 Press without a match and with a free voice SHALL write the keycode to the free voice, set its gate, clear its age and pulse its rden.
REQ-021 Press with all voices gated and no match SHALL pulse overflow and then follow REQ-037.
REQ-022 Release with a match SHALL clear that voice's gate and retain its keycode (for the release envelope), with no rden pulse.
REQ-023 Release without a match SHALL be ignored.
REQ-024 On every assignment or retrigger, every other gated voice's age SHALL increment, saturating at 2^AGE_W-1; non-gated voices hold their age.
REQ-025 In IDLE with no accepted event, if octave differs from octave_out, octave_out SHALL latch octave and rden SHALL pulse for every voice whose keycode is nonzero, for one cycle.
REQ-026 An accepted event SHALL take priority over an octave change in the same cycle; the octave change is handled in the next IDLE cycle without an event.
REQ-027 rden SHALL be 0 in every cycle not named in REQ-019, REQ-020, REQ-025 or REQ-037.

Reset
REQ-028 Reset SHALL force state IDLE, key_ready 1, keycodes 0, gate 0, rden 0, overflow 0, octave_out 0 and all ages 0.
REQ-029 Reset asserted mid-event (in LOOKUP or UPDATE) SHALL abandon the event with no output update.
REQ-030 Reset SHALL override any simultaneous key_valid.

Configuration
REQ-031 Macro VOICE_STEAL_EN SHALL select the full-voice policy.
REQ-032 Both settings SHALL keep the overflow pulse of REQ-021.
REQ-033 The default configuration SHALL be VOICE_STEAL_EN undefined.
REQ-034 Each FSM state transition SHALL be identical with or without VOICE_STEAL_EN.
REQ-035 No port, parameter or reset value SHALL differ between the two builds.
REQ-036 Without VOICE_STEAL_EN, the full-voice press SHALL be dropped with no voice change.
REQ-037 With VOICE_STEAL_EN defined, the full-voice press SHALL be written into the oldest voice: keycode replaced, gate stays 1, age cleared, rden pulses.

Structure
REQ-038 Package voice_alloc_pkg SHALL hold the state enum, KEYCODE_W=8, OCTAVE_W=3 and the KEY_INVALID=8'h00 constant.
REQ-039 Sub-module oldest_voice_finder (combinational, parameterised on NUMVOICES and AGE_W) SHALL return the oldest index per REQ-018.

Verification
REQ-040 Reset, then press 0x1C -> 3 cycles later keycodes[0]=0x1C, gate=0001, rden=0001 for 1 cycle.
REQ-041 Press 0x1C, 0x1B, 0x23, 0x2B, then 0x24 -> overflow pulse; with VOICE_STEAL_EN, keycodes[0]=0x24 and rden[0] pulses; without it, no change.
REQ-042 Release 0x1B (held in voice 1) -> gate[1]=0, keycodes[1] stays 0x1B, no rden; a following release of 0x55 -> no change.
REQ-043 Change octave 0->2 while idle with voices 0 and 1 loaded -> octave_out=2 next cycle and rden=0011 for 1 cycle; octave change coincident with an accepted event -> the octave change is applied one cycle after return to IDLE.
REQ-044 Assert reset in LOOKUP of a press of 0x1C -> all outputs return to reset values and key_ready=1 next cycle.
